// File: rtl/alu_pkg.sv
// Opcode encodings (MIPS-style funct codes) and enable bit positions shared by the ALU files.
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_NOR = 6'h27;
    localparam logic [5:0] OP_SRL = 6'h02;
    localparam logic [5:0] OP_SRA = 6'h03;

    localparam int EN_A  = 0;
    localparam int EN_B  = 1;
    localparam int EN_OP = 2;

endpackage

// File: rtl/alu_exec.sv
// Combinational ALU core: maps (a, b, op) to a DATA_BUS+1 bit result whose MSB is carry/borrow.
module alu_exec
    import alu_pkg::*;
#(
    parameter int DATA_BUS = 8,
    parameter int OP_BUS   = 6
) (
    input  logic [DATA_BUS-1:0] a,
    input  logic [DATA_BUS-1:0] b,
    input  logic [OP_BUS-1:0]   op,
    output logic [DATA_BUS:0]   result
);

    // Wide compare so shift amounts at or beyond the operand width saturate.
    localparam int CW = (DATA_BUS > 32) ? DATA_BUS : 32;

    logic [CW-1:0]       b_ext;
    logic                big_shift;
    logic [DATA_BUS-1:0] sign_fill;

    always_comb begin
        b_ext     = CW'(b);
        big_shift = (b_ext >= CW'(DATA_BUS));
        sign_fill = {DATA_BUS{a[DATA_BUS-1]}};
    end

    always_comb begin
        result = '0;
        case (op)
            OP_ADD: result = {1'b0, a} + {1'b0, b};
            OP_SUB: result = {1'b0, a} - {1'b0, b};
            OP_AND: result = {1'b0, a & b};
            OP_OR:  result = {1'b0, a | b};
            OP_XOR: result = {1'b0, a ^ b};
            OP_NOR: result = {1'b0, ~(a | b)};
            OP_SRL: result = big_shift ? '0 : {1'b0, a >> b};
            OP_SRA: result = big_shift ? {1'b0, sign_fill}
                                       : {1'b0, DATA_BUS'($signed(a) >>> b)};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// ALU top: enable-gated operand/opcode latches feeding alu_exec.
// Define ALU_RESULT_REG_EN to register result_bus (one extra cycle of latency).
module alu
    import alu_pkg::*;
#(
    parameter int DATA_BUS = 8,
    parameter int OP_BUS   = 6
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [DATA_BUS-1:0] op_a_bus,
    input  logic [DATA_BUS-1:0] op_b_bus,
    input  logic [OP_BUS-1:0]   op_code_bus,
    input  logic [2:0]          enables,
    output logic [DATA_BUS:0]   result_bus
);

    logic [DATA_BUS-1:0] reg_a;
    logic [DATA_BUS-1:0] reg_b;
    logic [OP_BUS-1:0]   reg_op;
    logic [DATA_BUS:0]   exec_result;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reg_a  <= '0;
            reg_b  <= '0;
            reg_op <= '0;
        end else begin
            if (enables[EN_A])  reg_a  <= op_a_bus;
            if (enables[EN_B])  reg_b  <= op_b_bus;
            if (enables[EN_OP]) reg_op <= op_code_bus;
        end
    end

    alu_exec #(
        .DATA_BUS (DATA_BUS),
        .OP_BUS   (OP_BUS)
    ) u_exec (
        .a      (reg_a),
        .b      (reg_b),
        .op     (reg_op),
        .result (exec_result)
    );

`ifdef ALU_RESULT_REG_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) result_bus <= '0;
        else          result_bus <= exec_result;
    end
`else
    always_comb result_bus = exec_result;
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboarded directed test of alu; stimulus queues expected results, a negedge monitor checks them.
module tb_alu;

`ifdef ALU_RESULT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        int         due;
        logic [8:0] exp;
        string      name;
    } exp_t;

    logic       clock;
    logic       reset_n;
    logic [7:0] op_a_bus;
    logic [7:0] op_b_bus;
    logic [5:0] op_code_bus;
    logic [2:0] enables;
    logic [8:0] result_bus;

    exp_t q[$];
    int   cyc     = 0;
    int   n_cmp   = 0;
    int   n_bad   = 0;

    alu #(
        .DATA_BUS (8),
        .OP_BUS   (6)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .op_a_bus    (op_a_bus),
        .op_b_bus    (op_b_bus),
        .op_code_bus (op_code_bus),
        .enables     (enables),
        .result_bus  (result_bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: compare every queued expectation whose due cycle has arrived.
    always @(negedge clock) begin
        while (q.size() != 0 && q[0].due <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_cmp = n_cmp + 1;
            if (result_bus !== e.exp) begin
                n_bad = n_bad + 1;
                $display("FAIL %s: result_bus=%03h expected=%03h", e.name, result_bus, e.exp);
            end
        end
    end

    task automatic push(input int due, input logic [8:0] exp, input string name);
        exp_t e;
        e.due  = due;
        e.exp  = exp;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                        input logic [2:0] en, input logic [8:0] exp, input string name);
        @(negedge clock);
        #1;
        op_a_bus    = a;
        op_b_bus    = b;
        op_code_bus = op;
        enables     = en;
        @(posedge clock);
        #1;
        push(cyc + LAT, exp, name);
        enables = 3'b000;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clock);
    endtask

    initial begin
        reset_n     = 1'b0;
        op_a_bus    = 8'hC3;
        op_b_bus    = 8'h5A;
        op_code_bus = 6'h20;
        enables     = 3'b111;
        push(0, 9'h000, "reset");
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        enables = 3'b000;
        reset_n = 1'b1;

        step(8'hC3, 8'h5A, 6'h20, 3'b000, 9'h000, "post_reset_idle");
        step(8'h55, 8'hA7, 6'h20, 3'b111, 9'h0FC, "add_load_all");
        step(8'h55, 8'hD4, 6'h20, 3'b000, 9'h0FC, "add_gated_b");
        step(8'h55, 8'hD4, 6'h20, 3'b010, 9'h129, "add_carry");
        step(8'h00, 8'h00, 6'h22, 3'b100, 9'h181, "sub_borrow");
        step(8'h00, 8'h15, 6'h00, 3'b010, 9'h040, "sub_no_borrow");
        step(8'hFF, 8'hFF, 6'h24, 3'b100, 9'h015, "and");
        step(8'hFF, 8'hFF, 6'h25, 3'b100, 9'h055, "or");
        step(8'hFF, 8'hFF, 6'h26, 3'b100, 9'h040, "xor");
        step(8'hFF, 8'hFF, 6'h27, 3'b100, 9'h0AA, "nor");
        step(8'hFF, 8'hFF, 6'h02, 3'b100, 9'h000, "srl_big");
        step(8'h88, 8'hFF, 6'h03, 3'b101, 9'h0FF, "sra_big");
        step(8'h00, 8'h03, 6'h00, 3'b010, 9'h0F1, "sra_3");
        step(8'h00, 8'h00, 6'h02, 3'b100, 9'h011, "srl_3");
        step(8'h00, 8'h00, 6'h3F, 3'b100, 9'h000, "unknown_op");
        step(8'h00, 8'h00, 6'h20, 3'b100, 9'h08B, "add_reload");

        drain();
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        push(cyc, 9'h000, "reset_mid_op");
        @(negedge clock);
        #2;
        reset_n = 1'b1;

        step(8'h77, 8'h66, 6'h20, 3'b000, 9'h000, "after_reset_idle");
        step(8'h01, 8'h02, 6'h20, 3'b111, 9'h003, "after_reset_load");

        drain();
        if (q.size() != 0) begin
            $display("FAIL drain: pending=%0d expected=0", q.size());
            n_bad = n_bad + q.size();
            n_cmp = n_cmp + q.size();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim_time=%0t expected=finish", $time);
        $fatal(1, "timeout");
    end

endmodule
